// File: rtl/sdram_port_arb_if.sv
// Bundle of the two client ports and the SDRAM controller side of sdram_port_arb.
// Handshake: a client holds req with we/addr/len/wdata; it owns the SDRAM from the edge its gnt rises until its single done pulse, and the SDRAM-side wr/rd request is held until the first matching ack.
interface sdram_port_arb_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10,
  parameter int DATA_W = 16
);
  logic                  init_end;
  logic [1:0]            req;
  logic [1:0]            we;
  logic [2*ADDR_W-1:0]   addr;
  logic [2*LEN_W-1:0]    len;
  logic [2*DATA_W-1:0]   wdata;
  logic [1:0]            gnt;
  logic [1:0]            wr_ack;
  logic [1:0]            rd_ack;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            done;

  logic                  sdram_wr_req;
  logic                  sdram_rd_req;
  logic [ADDR_W-1:0]     sdram_wr_addr;
  logic [ADDR_W-1:0]     sdram_rd_addr;
  logic [LEN_W-1:0]      sdram_wr_bst_len;
  logic [LEN_W-1:0]      sdram_rd_bst_len;
  logic [DATA_W-1:0]     sdram_wr_data;
  logic [DATA_W-1:0]     sdram_rd_data;
  logic                  sdram_wr_ack;
  logic                  sdram_rd_ack;

  modport slave (
    input  init_end, req, we, addr, len, wdata,
    input  sdram_rd_data, sdram_wr_ack, sdram_rd_ack,
    output gnt, wr_ack, rd_ack, rdata, done,
    output sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
    output sdram_wr_bst_len, sdram_rd_bst_len, sdram_wr_data
  );

  modport master (
    output init_end, req, we, addr, len, wdata,
    output sdram_rd_data, sdram_wr_ack, sdram_rd_ack,
    input  gnt, wr_ack, rd_ack, rdata, done,
    input  sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
    input  sdram_wr_bst_len, sdram_rd_bst_len, sdram_wr_data
  );
endinterface

// File: rtl/sdram_port_arb.sv
// Two-port round-robin arbiter in front of an SDRAM controller: one burst
// transaction at a time, latched at grant, counted by the controller's acks.
module sdram_port_arb #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  sdram_port_arb_if.slave   bus,
  output logic [1:0]        o_dbg_state,
  output logic              o_dbg_sel
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_sel;
  logic                r_last;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W:0]      r_cnt;
  logic                r_wr_req;
  logic                r_rd_req;

  logic                w_win;
  logic                w_win_we;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [LEN_W-1:0]    w_win_len;
  logic                w_start;
  logic                w_ack;
  logic [LEN_W:0]      w_cnt_inc;
  logic                w_last_word;
  logic [1:0]          w_sel_oh;

  // With both ports requesting, the one not served last wins.
  assign w_win      = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  assign w_win_we   = w_win ? bus.we[1] : bus.we[0];
  assign w_win_addr = w_win ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
  assign w_win_len  = w_win ? bus.len[2*LEN_W-1:LEN_W]    : bus.len[LEN_W-1:0];
  assign w_start    = (r_state == S_IDLE) && bus.init_end && (bus.req != 2'b00);

  // Only acks in the latched direction advance the burst.
  assign w_ack       = r_we ? bus.sdram_wr_ack : bus.sdram_rd_ack;
  assign w_cnt_inc   = r_cnt + {{LEN_W{1'b0}}, 1'b1};
  assign w_last_word = w_ack && (w_cnt_inc == {1'b0, r_len});

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = (w_win_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_last_word) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel    <= 1'b0;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_sel    <= w_win;
            r_we     <= w_win_we;
            r_addr   <= w_win_addr;
            r_len    <= w_win_len;
            r_cnt    <= '0;
            r_wr_req <= (w_win_len != '0) && w_win_we;
            r_rd_req <= (w_win_len != '0) && !w_win_we;
          end
        end
        S_RUN: begin
          if (bus.sdram_wr_ack) begin
            r_wr_req <= 1'b0;
          end
          if (bus.sdram_rd_ack) begin
            r_rd_req <= 1'b0;
          end
          if (w_ack) begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE: begin
          r_last   <= r_sel;
          r_cnt    <= '0;
          r_wr_req <= 1'b0;
          r_rd_req <= 1'b0;
        end
        default: begin
          r_cnt    <= '0;
          r_wr_req <= 1'b0;
          r_rd_req <= 1'b0;
        end
      endcase
    end
  end

  assign w_sel_oh = r_sel ? 2'b10 : 2'b01;

  // Grant and done are decoded from state so reset clears them without a clock.
  assign bus.gnt    = (r_state != S_IDLE) ? w_sel_oh : 2'b00;
  assign bus.done   = (r_state == S_DONE) ? w_sel_oh : 2'b00;
  assign bus.wr_ack = ((r_state == S_RUN) && r_we && bus.sdram_wr_ack)  ? w_sel_oh : 2'b00;
  assign bus.rd_ack = ((r_state == S_RUN) && !r_we && bus.sdram_rd_ack) ? w_sel_oh : 2'b00;
  assign bus.rdata  = bus.sdram_rd_data;

  assign bus.sdram_wr_req     = r_wr_req;
  assign bus.sdram_rd_req     = r_rd_req;
  assign bus.sdram_wr_addr    = r_wr_req ? r_addr : '0;
  assign bus.sdram_rd_addr    = r_rd_req ? r_addr : '0;
  assign bus.sdram_wr_bst_len = r_wr_req ? r_len  : '0;
  assign bus.sdram_rd_bst_len = r_rd_req ? r_len  : '0;
  assign bus.sdram_wr_data    = r_sel ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];

  assign o_dbg_state = r_state;
  assign o_dbg_sel   = r_sel;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed + randomized bench for sdram_port_arb; expected grants come from a
// round-robin model, expected strobes/data from the transaction's own parameters.
module tb_sdram_port_arb;
  localparam int AW = 24;
  localparam int LW = 10;
  localparam int DW = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic       dbg_sel;

  sdram_port_arb_if #(.ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) bus ();

  sdram_port_arb #(.ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_sel   (dbg_sel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit            last_served;
  bit            p_we   [2];
  logic [AW-1:0] p_addr [2];
  logic [LW-1:0] p_len  [2];
  logic [1:0]    exp_q  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] predict(input logic [1:0] rq);
    if (rq == 2'b11) return last_served ? 2'b01 : 2'b10;
    return rq;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 2'b00;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_served = 1'b1;
  endtask

  // One full transaction; the expected grant is popped from exp_q.
  task automatic txn(input logic [1:0] rq, input bit hold);
    logic [1:0]    eg;
    int            w;
    bit            t_we;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    logic [DW-1:0] rd;
    int            gap;
    eg = exp_q.pop_front();
    w  = eg[1] ? 1 : 0;
    t_we = p_we[w];
    a    = p_addr[w];
    l    = p_len[w];
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      bus.we[p]             = p_we[p];
      bus.addr[p*AW +: AW]  = p_addr[p];
      bus.len[p*LW +: LW]   = p_len[p];
    end
    bus.req      = rq;
    bus.init_end = 1'b1;
    #1;
    chk("idle_gnt", 32'(bus.gnt), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    if (!hold) begin
      bus.req  = 2'b00;
      bus.we   = ~bus.we;
      bus.addr = (2*AW)'({$urandom, $urandom});
      bus.len  = (2*LW)'($urandom);
    end
    bus.init_end = 1'($urandom_range(0, 1));
    #1;
    chk("grant", 32'(bus.gnt), 32'(eg));
    chk("dbg_sel", 32'(dbg_sel), 32'(w));
    if (l == '0) begin
      chk("len0_done", 32'(bus.done), 32'(eg));
      chk("len0_wr_req", 32'(bus.sdram_wr_req), 32'd0);
      chk("len0_rd_req", 32'(bus.sdram_rd_req), 32'd0);
    end else begin
      chk("wr_req", 32'(bus.sdram_wr_req), 32'(t_we));
      chk("rd_req", 32'(bus.sdram_rd_req), 32'(!t_we));
      chk("wr_addr", 32'(bus.sdram_wr_addr), t_we ? 32'(a) : 32'd0);
      chk("rd_addr", 32'(bus.sdram_rd_addr), t_we ? 32'd0 : 32'(a));
      chk("wr_len", 32'(bus.sdram_wr_bst_len), t_we ? 32'(l) : 32'd0);
      chk("rd_len", 32'(bus.sdram_rd_bst_len), t_we ? 32'd0 : 32'(l));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        #1;
        chk("req_wait", 32'(t_we ? bus.sdram_wr_req : bus.sdram_rd_req), 32'd1);
      end
      for (int k = 0; k < int'(l); k++) begin
        @(negedge clk);
        bus.sdram_wr_ack  = t_we ? 1'b1 : 1'($urandom_range(0, 1));
        bus.sdram_rd_ack  = t_we ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.wdata         = $urandom;
        rd                = DW'($urandom);
        bus.sdram_rd_data = rd;
        #1;
        chk("wr_ack", 32'(bus.wr_ack), t_we ? 32'(eg) : 32'd0);
        chk("rd_ack", 32'(bus.rd_ack), t_we ? 32'd0 : 32'(eg));
        chk("wr_data", 32'(bus.sdram_wr_data), 32'(bus.wdata[w*DW +: DW]));
        chk("rdata", 32'(bus.rdata), 32'(rd));
        chk("req_drop", 32'(t_we ? bus.sdram_wr_req : bus.sdram_rd_req), (k == 0) ? 32'd1 : 32'd0);
        chk("burst_done", 32'(bus.done), 32'd0);
      end
      @(negedge clk);
      bus.sdram_wr_ack = 1'b0;
      bus.sdram_rd_ack = 1'b0;
      #1;
      chk("done", 32'(bus.done), 32'(eg));
      chk("done_gnt", 32'(bus.gnt), 32'(eg));
      chk("done_wr_req", 32'(bus.sdram_wr_req), 32'd0);
      chk("done_rd_req", 32'(bus.sdram_rd_req), 32'd0);
    end
    last_served = w[0];
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.init_end         = 1'b0;
    bus.req              = 2'b00;
    bus.we               = 2'b00;
    bus.addr             = '0;
    bus.len              = '0;
    bus.wdata            = '0;
    bus.sdram_rd_data    = '0;
    bus.sdram_wr_ack     = 1'b0;
    bus.sdram_rd_ack     = 1'b0;
    last_served          = 1'b1;
    #1;
    chk("por_gnt", 32'(bus.gnt), 32'd0);
    chk("por_done", 32'(bus.done), 32'd0);
    chk("por_wr_req", 32'(bus.sdram_wr_req), 32'd0);
    chk("por_rd_req", 32'(bus.sdram_rd_req), 32'd0);
    chk("por_wr_addr", 32'(bus.sdram_wr_addr), 32'd0);
    chk("por_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // init_end gates the IDLE exit
    p_we[0] = 1'b1; p_addr[0] = 24'h00_0040; p_len[0] = 10'd3;
    p_we[1] = 1'b0; p_addr[1] = 24'h00_0080; p_len[1] = 10'd3;
    bus.req = 2'b01;
    bus.we  = 2'b01;
    bus.len = {p_len[1], p_len[0]};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      chk("gate_gnt", 32'(bus.gnt), 32'd0);
      chk("gate_wr_req", 32'(bus.sdram_wr_req), 32'd0);
    end
    exp_q.push_back(2'b01);
    txn(2'b01, 1'b0);

    // port 0 write of 10 words
    p_we[0] = 1'b1; p_addr[0] = 24'h00_0100; p_len[0] = 10'd10;
    exp_q.push_back(predict(2'b01));
    txn(2'b01, 1'b0);

    // port 1 read of 4 words
    p_we[1] = 1'b0; p_addr[1] = 24'h12_3456; p_len[1] = 10'd4;
    exp_q.push_back(predict(2'b10));
    txn(2'b10, 1'b0);

    // zero-length request completes without touching the SDRAM
    p_len[0] = 10'd0;
    exp_q.push_back(predict(2'b01));
    txn(2'b01, 1'b0);

    // both ports requesting continuously alternate starting with port 0
    do_reset();
    p_we[0] = 1'b1; p_addr[0] = 24'h00_0200; p_len[0] = 10'd2;
    p_we[1] = 1'b0; p_addr[1] = 24'h00_0300; p_len[1] = 10'd2;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    for (int t = 0; t < 4; t++) txn(2'b11, 1'b1);
    bus.req = 2'b00;

    // randomized traffic against the round-robin model
    for (int t = 0; t < 24; t++) begin
      logic [1:0] rq;
      for (int p = 0; p < 2; p++) begin
        p_we[p]   = 1'($urandom_range(0, 1));
        p_addr[p] = AW'($urandom);
        p_len[p]  = LW'($urandom_range(0, 6));
      end
      rq = 2'($urandom_range(1, 3));
      exp_q.push_back(predict(rq));
      txn(rq, 1'($urandom_range(0, 1)));
    end
    bus.req = 2'b00;

    // reset in the middle of a burst abandons it
    @(negedge clk);
    bus.we  = 2'b01;
    bus.len = {10'd8, 10'd8};
    bus.req = 2'b01;
    bus.init_end = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_gnt", 32'(bus.gnt), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.sdram_wr_ack = 1'b1;
    end
    @(negedge clk);
    bus.sdram_wr_ack = 1'b0;
    bus.req = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("abort_gnt0", 32'(bus.gnt), 32'd0);
    chk("abort_wr_req", 32'(bus.sdram_wr_req), 32'd0);
    chk("abort_wr_addr", 32'(bus.sdram_wr_addr), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    #1;
    chk("abort_done2", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    last_served = 1'b1;
    p_we[0] = 1'b0; p_addr[0] = 24'h00_0500; p_len[0] = 10'd1;
    p_we[1] = 1'b1; p_addr[1] = 24'h00_0600; p_len[1] = 10'd1;
    exp_q.push_back(predict(2'b11));
    txn(2'b11, 1'b0);

    @(negedge clk);
    #1;
    chk("end_gnt", 32'(bus.gnt), 32'd0);
    chk("end_done", 32'(bus.done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 Parameter ADDR_W, default 24: SDRAM word address width.
REQ-002 Parameter LEN_W, default 10: burst length width.
REQ-003 Parameter DATA_W, default 16: data word width.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 init_end  in  1  SDRAM controller initialisation complete.
REQ-007 req  in  2  per-port transaction request; bit i = port i.
REQ-008 we  in  2  per-port direction; 1 = write, 0 = read.
REQ-009 addr  in  2*ADDR_W  per-port start address; port i at [i*ADDR_W +: ADDR_W].
REQ-010 len  in  2*LEN_W  per-port burst length in words; same packing as addr.
REQ-011 wdata  in  2*DATA_W  per-port write data; same packing.
REQ-012 gnt  out  2  one-hot grant, high for the whole transaction.
REQ-013 wr_ack / rd_ack  out  2 each  per-port data strobes.
REQ-014 rdata  out  DATA_W  read data, shared by both ports.
REQ-015 done  out  2  one-cycle transaction-complete pulse per port.
REQ-016 sdram_wr_req, sdram_rd_req  out  1 each  requests to SDRAM controller.
REQ-017 sdram_wr_addr, sdram_rd_addr  out  ADDR_W; sdram_wr_bst_len, sdram_rd_bst_len  out  LEN_W.
REQ-018 sdram_wr_data  out  DATA_W; sdram_rd_data  in  DATA_W.
REQ-019 sdram_wr_ack, sdram_rd_ack  in  1 each  controller per-word strobes.

Function
REQ-020 FSM states IDLE, RUN, DONE; a registered pointer sel records the granted port.
REQ-021 IDLE exits only when init_end=1 and req!=0; otherwise holds with all requests low.
REQ-022 Arbitration is round-robin: when both ports request, the port not served last wins; a single requester always wins.
REQ-023 On the exit edge from IDLE, the arbiter latches we, addr and len of the winner and sets gnt[sel]=1.
REQ-024 Winner with len!=0 -> RUN; on the same edge, sdram_wr_req (we=1) or sdram_rd_req (we=0) goes high.
REQ-025 Winner with len=0 -> DONE directly; no SDRAM request is issued.
REQ-026 sdram_*_addr and sdram_*_bst_len are driven from latched values whenever the corresponding request is high; they are 0 otherwise.
REQ-027 The SDRAM request stays high until the first cycle its matching ack is high; it is deasserted on the following edge.
REQ-028 In RUN, a LEN_W+1-bit counter increments on each cycle the matching ack is high; acks of the opposite direction are ignored.
REQ-029 wr_ack[sel] is combinationally equal to sdram_wr_ack when RUN and latched we=1; rd_ack[sel] likewise for reads; the other port's ack bits stay 0.
REQ-030 sdram_wr_data = wdata[sel] combinationally; rdata = sdram_rd_data pass-through.
REQ-031 RUN -> DONE on the edge where the counter reaches the latched len.
REQ-032 DONE lasts exactly one cycle: done[sel]=1, gnt=0 on exit, last-served updated to sel, counter cleared, -> IDLE.
REQ-033 Changes to req, we, addr or len of any port during RUN/DONE are ignored; deasserting req[sel] does not abort.
REQ-034 A requester still asserting req in IDLE after done is treated as a new request.
REQ-035 init_end falling during RUN has no effect; it gates only IDLE exit.

Reset
REQ-036 rst_n low forces state IDLE, gnt, done, all SDRAM requests, addr/len outputs and counter to 0 immediately, independent of clk.
REQ-037 Reset sets last-served to port 1, so port 0 wins the first simultaneous arbitration.
REQ-038 Reset mid-transaction abandons it; no done pulse is produced.

Verification
REQ-039 init_end=0, req=01 for 20 cycles -> gnt=00, no SDRAM req; raise init_end -> gnt=01 and sdram_wr_req=1 one edge later.
REQ-040 Port 0 write, addr=0x000100, len=10, model acks 10 cycles -> wr_ack[0] high 10 cycles, sdram_wr_data tracks wdata[0], single done[0], gnt=00.
REQ-041 Port 1 read, len=4 -> sdram_rd_bst_len=4, rd_ack[1] high 4 cycles, rdata=sdram_rd_data, wr_ack=00 throughout.
REQ-042 req=11 held continuously after reset, len=2 each -> grants 01,10,01,10 in order.
REQ-043 Port 0 request with len=0 -> done[0] pulse, sdram_wr_req and sdram_rd_req never asserted.
REQ-044 rst_n low mid-RUN -> gnt and sdram requests drop immediately; after release, req=11 -> port 0 granted first.
